// File: rtl/coproc_mem_pkg.sv
// Shared types and constants for the coprocessor block-memory arbiter.
package coproc_mem_pkg;

  typedef enum logic {
    REQ_HOST   = 1'b0,
    REQ_ENGINE = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    ST_ARB         = 2'd0,
    ST_LOCK_HOST   = 2'd1,
    ST_LOCK_ENGINE = 2'd2
  } arb_state_t;

  localparam int CONFIG_ADDR  = 0;
  localparam int STATUS_ADDR  = 1;
  localparam int RESERVED_TOP = 2;

  function automatic req_id_t other_side(input req_id_t id);
    return (id == REQ_HOST) ? REQ_ENGINE : REQ_HOST;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the pointer side.
module mem_rr_pick
  import coproc_mem_pkg::*;
(
  input  logic    [1:0] reqs,
  input  req_id_t       pointer,
  output logic          any_req,
  output req_id_t       winner
);

  always_comb begin
    any_req = |reqs;
    winner  = pointer;
    if (reqs[0] && !reqs[1]) begin
      winner = REQ_HOST;
    end else if (!reqs[0] && reqs[1]) begin
      winner = REQ_ENGINE;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Host/engine arbiter for the single-port coprocessor block memory, with
// lock bursts, range rejection, status-word routing and tagged 1-cycle read return.
module mem_access_arbiter
  import coproc_mem_pkg::*;
#(
  parameter int size       = 1024,
  parameter int blocks     = 4,
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int width      = blocks * cell_width,
  parameter int max_lock   = 16
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_host_req,
  input  logic                  in_host_we,
  input  logic                  in_host_lock,
  input  logic [log_size-1:0]   in_host_address,
  input  logic [width-1:0]      in_host_data,
  input  logic                  in_engine_req,
  input  logic                  in_engine_we,
  input  logic                  in_engine_lock,
  input  logic [log_size-1:0]   in_engine_address,
  input  logic [width-1:0]      in_engine_data,
  output logic                  out_host_grant,
  output logic                  out_engine_grant,
  output logic                  out_host_rvalid,
  output logic                  out_engine_rvalid,
  output logic [width-1:0]      out_rdata,
  output logic                  out_error,
  input  logic                  in_engine_status_we,
  input  logic [cell_width-1:0] in_engine_status,
  output logic [log_size-1:0]   out_mem_address,
  output logic [width-1:0]      out_mem_data,
  output logic                  out_mem_read_en,
  output logic                  out_mem_write_en,
  output logic [cell_width-1:0] out_mem_status,
  output logic                  out_mem_write_status_en,
  input  logic [width-1:0]      in_mem_data
);

  localparam int CNT_W = $clog2(max_lock + 1);
  localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(max_lock);
  localparam logic [CNT_W-1:0]    ONE_CNT   = CNT_W'(1);
  localparam logic [log_size-1:0] LAST_BASE = log_size'(size - blocks);
  localparam logic [log_size-1:0] RES_TOP   = log_size'(RESERVED_TOP);

  arb_state_t       state_reg, state_next;
  req_id_t          ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rv_valid_reg, rv_valid_next;
  req_id_t          rv_owner_reg, rv_owner_next;
  logic             rv_error_reg, rv_error_next;

  // Per-side views, index 0 = host, 1 = engine.
  logic [1:0]          req, we, lock, elig, bad, grant, grant_g;
  logic [log_size-1:0] addr  [2];
  logic [width-1:0]    wdata [2];

  assign req      = {in_engine_req,     in_host_req};
  assign we       = {in_engine_we,      in_host_we};
  assign lock     = {in_engine_lock,    in_host_lock};
  assign addr[0]  = in_host_address;
  assign addr[1]  = in_engine_address;
  assign wdata[0] = in_host_data;
  assign wdata[1] = in_engine_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      localparam bit IS_ENGINE = (gi == 1);
      assign bad[gi] = (addr[gi] > LAST_BASE) ||
                       (IS_ENGINE && we[gi] && (addr[gi] < RES_TOP));
    end
  endgenerate

  // A host write into the config/status cells yields to a same-cycle status post.
  logic host_blocked;
  assign host_blocked = in_host_we && (in_host_address < RES_TOP) && in_engine_status_we;
  assign elig = {in_engine_req, in_host_req && !host_blocked};

  logic    arb_any;
  req_id_t arb_winner;

  mem_rr_pick u_rr_pick (
    .reqs    (elig),
    .pointer (ptr_reg),
    .any_req (arb_any),
    .winner  (arb_winner)
  );

  req_id_t lock_side, lock_other;
  assign lock_side  = (state_reg == ST_LOCK_ENGINE) ? REQ_ENGINE : REQ_HOST;
  assign lock_other = other_side(lock_side);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    grant      = 2'b00;
    case (state_reg)
      ST_ARB: begin
        if (arb_any) begin
          grant[arb_winner] = 1'b1;
          ptr_next          = other_side(arb_winner);
          if (lock[arb_winner]) begin
            state_next = (arb_winner == REQ_HOST) ? ST_LOCK_HOST : ST_LOCK_ENGINE;
            count_next = ONE_CNT;
          end
        end
      end
      ST_LOCK_HOST, ST_LOCK_ENGINE: begin
        // An exhausted lock hands the next arbitration to the waiting side.
        if (req[lock_other] && (count_reg == MAX_CNT)) begin
          state_next = ST_ARB;
          ptr_next   = lock_other;
        end else if (elig[lock_side]) begin
          grant[lock_side] = 1'b1;
          if (count_reg != MAX_CNT) begin
            count_next = count_reg + ONE_CNT;
          end
          if (!lock[lock_side]) begin
            state_next = ST_ARB;
          end
        end else if (!req[lock_side]) begin
          state_next = ST_ARB;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  req_id_t win;
  logic    any_grant, access;

  assign grant_g   = grant & {2{in_reset}};
  assign any_grant = |grant_g;
  assign win       = grant_g[1] ? REQ_ENGINE : REQ_HOST;
  assign access    = any_grant && !bad[win];

  assign out_host_grant   = grant_g[0];
  assign out_engine_grant = grant_g[1];
  assign out_mem_read_en  = access && !we[win];
  assign out_mem_write_en = access && we[win];
  assign out_mem_address  = access ? addr[win] : '0;
  assign out_mem_data     = out_mem_write_en ? wdata[win] : '0;

  assign out_mem_write_status_en = in_engine_status_we && in_reset;
  assign out_mem_status          = out_mem_write_status_en ? in_engine_status : '0;

  // Reads and rejected beats of either kind return a tagged response.
  assign rv_valid_next = any_grant && (!we[win] || bad[win]);
  assign rv_owner_next = win;
  assign rv_error_next = bad[win];

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_reg    <= ST_ARB;
      ptr_reg      <= REQ_HOST;
      count_reg    <= '0;
      rv_valid_reg <= 1'b0;
      rv_owner_reg <= REQ_HOST;
      rv_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
      rv_valid_reg <= rv_valid_next;
      rv_owner_reg <= rv_owner_next;
      rv_error_reg <= rv_error_next;
    end
  end

  assign out_host_rvalid   = rv_valid_reg && (rv_owner_reg == REQ_HOST);
  assign out_engine_rvalid = rv_valid_reg && (rv_owner_reg == REQ_ENGINE);
  assign out_error         = rv_valid_reg && rv_error_reg;
  assign out_rdata         = (rv_valid_reg && !rv_error_reg) ? in_mem_data : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a behavioural block memory.
module tb_mem_access_arbiter;

  localparam int SIZE = 1024;
  localparam int CW   = 32;
  localparam int W    = 4 * CW;

  logic          in_clk = 1'b0;
  logic          in_reset;
  logic          h_req, h_we, h_lock, e_req, e_we, e_lock, st_we;
  logic [9:0]    h_addr, e_addr;
  logic [W-1:0]  h_data, e_data;
  logic [CW-1:0] st_val;
  logic          h_grant, e_grant, h_rvalid, e_rvalid, err;
  logic [W-1:0]  rdata, mem_wdata, mem_rdata;
  logic [9:0]    mem_addr;
  logic          mem_rd, mem_wr, mem_st_en;
  logic [CW-1:0] mem_st;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 in_clk = ~in_clk;

  mem_access_arbiter dut (
    .in_clk                  (in_clk),
    .in_reset                (in_reset),
    .in_host_req             (h_req),
    .in_host_we              (h_we),
    .in_host_lock            (h_lock),
    .in_host_address         (h_addr),
    .in_host_data            (h_data),
    .in_engine_req           (e_req),
    .in_engine_we            (e_we),
    .in_engine_lock          (e_lock),
    .in_engine_address       (e_addr),
    .in_engine_data          (e_data),
    .out_host_grant          (h_grant),
    .out_engine_grant        (e_grant),
    .out_host_rvalid         (h_rvalid),
    .out_engine_rvalid       (e_rvalid),
    .out_rdata               (rdata),
    .out_error               (err),
    .in_engine_status_we     (st_we),
    .in_engine_status        (st_val),
    .out_mem_address         (mem_addr),
    .out_mem_data            (mem_wdata),
    .out_mem_read_en         (mem_rd),
    .out_mem_write_en        (mem_wr),
    .out_mem_status          (mem_st),
    .out_mem_write_status_en (mem_st_en),
    .in_mem_data             (mem_rdata)
  );

  // Behavioural memory: cell i resets to C000_0000 | i, registered read.
  logic [CW-1:0] mem [SIZE];
  logic [W-1:0]  rd_q;
  logic          rd_v;

  always @(posedge in_clk) begin
    if (!in_reset) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= 32'hC000_0000 | 32'(i);
      rd_v <= 1'b0;
    end else begin
      if (mem_wr) for (int i = 0; i < 4; i++) mem[int'(mem_addr) + i] <= mem_wdata[i*CW +: CW];
      if (mem_st_en) mem[1] <= mem_st;
      rd_v <= mem_rd;
      if (mem_rd) for (int i = 0; i < 4; i++) rd_q[i*CW +: CW] <= mem[int'(mem_addr) + i];
    end
  end
  assign mem_rdata = rd_v ? rd_q : '0;

  function automatic logic [W-1:0] row(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*CW +: CW] = 32'hC000_0000 | 32'(base + i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic idle();
    h_req = 0; h_we = 0; h_lock = 0; h_addr = '0; h_data = '0;
    e_req = 0; e_we = 0; e_lock = 0; e_addr = '0; e_data = '0;
    st_we = 0; st_val = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":hgnt"}, W'(h_grant), '0);
    check({tag, ":egnt"}, W'(e_grant), '0);
    check({tag, ":rvalid"}, W'({h_rvalid, e_rvalid}), '0);
    check({tag, ":err"}, W'(err), '0);
    check({tag, ":strobes"}, W'({mem_rd, mem_wr, mem_st_en}), '0);
    check({tag, ":maddr"}, W'(mem_addr), '0);
    check({tag, ":mdata"}, mem_wdata, '0);
    check({tag, ":rdata"}, rdata, '0);
  endtask

  // One isolated beat: grant and strobes in the request cycle, response the cycle after.
  task automatic do_beat(input string tag, input bit eng, input bit wr, input logic [9:0] a,
                         input logic [W-1:0] d, input bit exp_strobe, input bit exp_rv,
                         input bit exp_err, input logic [W-1:0] exp_rdata);
    @(negedge in_clk);
    if (eng) begin e_req = 1; e_we = wr; e_addr = a; e_data = d; end
    else     begin h_req = 1; h_we = wr; h_addr = a; h_data = d; end
    #1;
    check({tag, ":grant"}, W'(eng ? e_grant : h_grant), W'(1));
    check({tag, ":rd_en"}, W'(mem_rd), W'(exp_strobe && !wr));
    check({tag, ":wr_en"}, W'(mem_wr), W'(exp_strobe && wr));
    check({tag, ":maddr"}, W'(mem_addr), exp_strobe ? W'(a) : '0);
    @(negedge in_clk);
    idle();
    #1;
    check({tag, ":rvalid"}, W'(eng ? e_rvalid : h_rvalid), W'(exp_rv));
    check({tag, ":other_rvalid"}, W'(eng ? h_rvalid : e_rvalid), '0);
    check({tag, ":error"}, W'(err), W'(exp_err));
    check({tag, ":rdata"}, rdata, exp_rdata);
    $display("beat %s side=%0d we=%0d addr=%0d rvalid=%0d err=%0d rdata=%h",
             tag, eng, wr, a, eng ? e_rvalid : h_rvalid, err, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d1;
    int eng_beats, host_at, both;
    d1 = {32'd4, 32'd3, 32'd2, 32'd1};

    // Reset with requests pending: nothing may leak out.
    idle();
    in_reset = 0;
    h_req = 1; h_we = 1; h_data = d1; e_req = 1; st_we = 1; st_val = 32'hFF;
    repeat (3) @(negedge in_clk);
    #1;
    check_all_zero("reset");
    @(negedge in_clk);
    idle();
    in_reset = 1;

    // 1: host write then read at 8; engine read leaves the pointer at host.
    do_beat("t1_hwr", 0, 1, 10'd8, d1, 1, 0, 0, '0);
    do_beat("t1_hrd", 0, 0, 10'd8, '0, 1, 1, 0, d1);
    do_beat("t1_erd", 1, 0, 10'd8, '0, 1, 1, 0, d1);

    // 2: both reading every cycle alternate host/engine, each with 1-cycle latency.
    for (int k = 0; k <= 6; k++) begin
      @(negedge in_clk);
      if (k == 0) begin h_req = 1; h_addr = 10'd16; e_req = 1; e_addr = 10'd32; end
      if (k == 6) idle();
      #1;
      if (k < 6) begin
        check($sformatf("t2_hgnt%0d", k), W'(h_grant), W'(k % 2 == 0));
        check($sformatf("t2_egnt%0d", k), W'(e_grant), W'(k % 2 == 1));
      end
      if (k > 0) begin
        check($sformatf("t2_hrv%0d", k), W'(h_rvalid), W'((k - 1) % 2 == 0));
        check($sformatf("t2_erv%0d", k), W'(e_rvalid), W'((k - 1) % 2 == 1));
        check($sformatf("t2_rdata%0d", k), rdata, ((k - 1) % 2 == 0) ? row(16) : row(32));
      end
      $display("t2 cycle %0d hgnt=%0d egnt=%0d hrv=%0d erv=%0d", k, h_grant, e_grant, h_rvalid, e_rvalid);
    end

    // 3: engine lock burst with host waiting from the second cycle.
    eng_beats = 0; host_at = -1; both = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge in_clk);
      if (c == 0) begin e_req = 1; e_lock = 1; e_addr = 10'd64; end
      if (c == 1) begin h_req = 1; h_addr = 10'd16; end
      #1;
      if (e_grant && h_grant) both++;
      if (h_grant) begin host_at = c; break; end
      if (e_grant) eng_beats++;
    end
    check("t3_engine_beats", W'(eng_beats), W'(16));
    check("t3_host_grant_cycle", W'(host_at), W'(17));
    check("t3_dual_grant", W'(both), '0);
    $display("t3 engine_beats=%0d host_grant_cycle=%0d", eng_beats, host_at);
    @(negedge in_clk);
    idle();
    repeat (2) @(negedge in_clk);

    // 4: rejections and range boundaries.
    do_beat("t4_ewr_rsvd", 1, 1, 10'd1, {W{1'b1}}, 0, 1, 1, '0);
    do_beat("t4_hrd_oob", 0, 0, 10'd1021, '0, 0, 1, 1, '0);
    do_beat("t4_hrd_edge", 0, 0, 10'd1020, '0, 1, 1, 0, row(1020));
    do_beat("t4_hrd_cfg", 0, 0, 10'd0, '0, 1, 1, 0, row(0));
    do_beat("t4_hwr_stat", 0, 1, 10'd1, d1, 1, 0, 0, '0);

    // 5: status post defers a host config write by one cycle but not an engine beat.
    @(negedge in_clk);
    h_req = 1; h_we = 1; h_addr = 10'd0; h_data = d1; st_we = 1; st_val = 32'hA5;
    #1;
    check("t5_hgnt_blocked", W'(h_grant), '0);
    check("t5_st_en", W'(mem_st_en), W'(1));
    check("t5_st_val", W'(mem_st), W'(32'hA5));
    check("t5_wr_en_blocked", W'(mem_wr), '0);
    @(negedge in_clk);
    st_we = 0; st_val = '0;
    #1;
    check("t5_hgnt_late", W'(h_grant), W'(1));
    check("t5_wr_en_late", W'(mem_wr), W'(1));
    check("t5_st_en_off", W'(mem_st_en), '0);
    $display("t5 host config write granted after status post");
    @(negedge in_clk);
    idle();
    e_req = 1; e_addr = 10'd32; st_we = 1; st_val = 32'h5A;
    #1;
    check("t5_egnt_with_status", W'(e_grant), W'(1));
    check("t5_st_val2", W'(mem_st), W'(32'h5A));
    @(negedge in_clk);
    idle();
    @(negedge in_clk);

    // 6: reset right after a read grant drops the response and re-homes the pointer.
    h_req = 1; h_addr = 10'd16;
    #1;
    check("t6_hgnt", W'(h_grant), W'(1));
    #2;
    in_reset = 0;
    h_we = 1; h_data = d1; e_req = 1; e_addr = 10'd32; st_we = 1;
    @(negedge in_clk);
    #1;
    check_all_zero("t6_reset");
    @(negedge in_clk);
    in_reset = 1;
    idle();
    h_req = 1; h_addr = 10'd16; e_req = 1; e_addr = 10'd32;
    #1;
    check("t6_first_host", W'(h_grant), W'(1));
    check("t6_first_eng", W'(e_grant), '0);
    @(negedge in_clk);
    #1;
    check("t6_second_eng", W'(e_grant), W'(1));
    check("t6_host_rv", W'(h_rvalid), W'(1));
    $display("t6 post-reset arbitration host then engine");
    @(negedge in_clk);
    idle();
    repeat (2) @(negedge in_clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
